// File: rtl/ifm_buf_mgr.sv
// Fetches one IFM row (width*channel words) from memory into line buffer row%IFM_BUF_CNT.
// Latency: 2 cycles request->first read; buffer write 1 cycle after each read-data beat.
// Backpressure: read address held while ack is low; unlimited outstanding reads; busy requests dropped with error.
`ifndef W_SIZE
`define W_SIZE 8
`endif
`ifndef W_CHANNEL
`define W_CHANNEL 8
`endif

module ifm_buf_mgr #(
  parameter int W_SIZE      = `W_SIZE,
  parameter int W_CHANNEL   = `W_CHANNEL,
  parameter int IFM_BUF_CNT = 4,
  parameter int W_IFM_BUF   = 2,
  parameter int W_ADDR      = 32,
  parameter int W_DATA      = 32,
  parameter int W_BUF_ADDR  = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_req_load,
  input  logic [W_SIZE-1:0]     i_req_row,
  input  logic [W_SIZE-1:0]     q_width,
  input  logic [W_CHANNEL-1:0]  q_channel,
  input  logic [W_ADDR-1:0]     q_base_addr,
  output logic                  o_mem_rd_req,
  output logic [W_ADDR-1:0]     o_mem_rd_addr,
  input  logic                  i_mem_rd_ack,
  input  logic                  i_mem_rd_valid,
  input  logic [W_DATA-1:0]     i_mem_rd_data,
  output logic                  o_buf_we,
  output logic [W_IFM_BUF-1:0]  o_buf_sel,
  output logic [W_BUF_ADDR-1:0] o_buf_addr,
  output logic [W_DATA-1:0]     o_buf_wdata,
  output logic                  o_req_done,
  output logic                  o_busy,
  output logic                  o_req_err
);

  localparam int W_CNT = W_BUF_ADDR + 1;
  localparam int W_TOT = W_SIZE + W_CHANNEL;

  typedef enum logic [1:0] {IDLE, SETUP, FETCH, DONE} state_t;

  state_t               state;
  logic [W_SIZE-1:0]    row;
  logic [W_SIZE-1:0]    width;
  logic [W_CHANNEL-1:0] channel;
  logic [W_CNT-1:0]     total;
  logic [W_CNT-1:0]     issued;
  logic [W_CNT-1:0]     recv;
  logic [W_ADDR-1:0]    row_base;

  logic [W_TOT-1:0]     total_full;
  logic [W_ADDR-1:0]    row_base_c;
  logic [W_CNT-1:0]     issued_nxt;

  assign total_full = W_TOT'(width) * W_TOT'(channel);
  // Words are 4 bytes; a row occupies width*channel consecutive words in memory.
  assign row_base_c = q_base_addr + ((W_ADDR'(row) * W_ADDR'(total_full)) << 2);
  assign issued_nxt = issued + W_CNT'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      row           <= '0;
      width         <= '0;
      channel       <= '0;
      total         <= '0;
      issued        <= '0;
      recv          <= '0;
      row_base      <= '0;
      o_mem_rd_req  <= 1'b0;
      o_mem_rd_addr <= '0;
      o_buf_we      <= 1'b0;
      o_buf_sel     <= '0;
      o_buf_addr    <= '0;
      o_buf_wdata   <= '0;
      o_req_done    <= 1'b0;
      o_busy        <= 1'b0;
      o_req_err     <= 1'b0;
    end else begin
      o_buf_we   <= 1'b0;
      o_req_done <= 1'b0;
      o_req_err  <= i_req_load && (state != IDLE);
      case (state)
        IDLE: begin
          if (i_req_load) begin
            row     <= i_req_row;
            width   <= q_width;
            channel <= q_channel;
            issued  <= '0;
            recv    <= '0;
            o_busy  <= 1'b1;
            state   <= SETUP;
          end
        end
        SETUP: begin
          total    <= W_CNT'(total_full);
          row_base <= row_base_c;
          if (total_full == '0) begin
            o_req_done <= 1'b1;
            state      <= DONE;
          end else begin
            o_mem_rd_req  <= 1'b1;
            o_mem_rd_addr <= row_base_c;
            state         <= FETCH;
          end
        end
        FETCH: begin
          if (o_mem_rd_req && i_mem_rd_ack) begin
            issued <= issued_nxt;
            if (issued_nxt == total) o_mem_rd_req <= 1'b0;
            else o_mem_rd_addr <= row_base + (W_ADDR'(issued_nxt) << 2);
          end
          // Completion is seen one cycle after the final write, so done trails the last o_buf_we.
          if (i_mem_rd_valid && (recv != total)) begin
            o_buf_we    <= 1'b1;
            o_buf_sel   <= W_IFM_BUF'(row % W_SIZE'(IFM_BUF_CNT));
            o_buf_addr  <= recv[W_BUF_ADDR-1:0];
            o_buf_wdata <= i_mem_rd_data;
            recv        <= recv + W_CNT'(1);
          end else if (recv == total) begin
            o_req_done <= 1'b1;
            state      <= DONE;
          end
        end
        DONE: begin
          o_busy <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ifm_buf_mgr.sv
// Bench for ifm_buf_mgr: memory model with 2-cycle read latency feeding a write scoreboard.
module tb_ifm_buf_mgr;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_req_load = 1'b0;
  logic [7:0]  i_req_row = '0;
  logic [7:0]  q_width = '0;
  logic [7:0]  q_channel = '0;
  logic [31:0] q_base_addr = '0;
  logic        o_mem_rd_req;
  logic [31:0] o_mem_rd_addr;
  logic        i_mem_rd_ack;
  logic        i_mem_rd_valid;
  logic [31:0] i_mem_rd_data;
  logic        o_buf_we;
  logic [1:0]  o_buf_sel;
  logic [11:0] o_buf_addr;
  logic [31:0] o_buf_wdata;
  logic        o_req_done;
  logic        o_busy;
  logic        o_req_err;

  ifm_buf_mgr #(.W_SIZE(8), .W_CHANNEL(8)) dut (
    .clk(clk), .rst(rst), .i_req_load(i_req_load), .i_req_row(i_req_row),
    .q_width(q_width), .q_channel(q_channel), .q_base_addr(q_base_addr),
    .o_mem_rd_req(o_mem_rd_req), .o_mem_rd_addr(o_mem_rd_addr), .i_mem_rd_ack(i_mem_rd_ack),
    .i_mem_rd_valid(i_mem_rd_valid), .i_mem_rd_data(i_mem_rd_data),
    .o_buf_we(o_buf_we), .o_buf_sel(o_buf_sel), .o_buf_addr(o_buf_addr), .o_buf_wdata(o_buf_wdata),
    .o_req_done(o_req_done), .o_busy(o_busy), .o_req_err(o_req_err)
  );

  initial forever #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  sel;
    logic [11:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t sb[$];

  int n_total = 0;
  int n_bad = 0;
  int nacc, nwr, ndone, nerr, nvld, nhold;
  int ndone_all = 0;
  int exp_total = 0;
  int exp_sel = 0;
  int ack_mode = 0;
  logic [31:0] exp_base = '0;
  logic [31:0] first_acc, last_acc;
  logic [1:0]  last_sel;

  // Memory model and output monitor, both acting on the falling edge.
  initial begin : mem_model
    logic        vld_p[2];
    logic [31:0] dat_p[2];
    logic        ack, acc, we_prev, hold_pend, ack_ph;
    logic [31:0] hold_addr, exp_a;
    wr_t         exp_w;
    vld_p[0] = 1'b0; vld_p[1] = 1'b0; dat_p[0] = '0; dat_p[1] = '0;
    we_prev = 1'b0; hold_pend = 1'b0; ack_ph = 1'b0; hold_addr = '0;
    i_mem_rd_ack = 1'b0; i_mem_rd_valid = 1'b0; i_mem_rd_data = '0;
    nacc = 0; nwr = 0; ndone = 0; nerr = 0; nvld = 0; nhold = 0;
    first_acc = '0; last_acc = '0; last_sel = '0;
    forever begin
      @(negedge clk);
      if (o_buf_we) begin
        nwr++;
        last_sel = o_buf_sel;
        n_total++;
        if (sb.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_write got sel=%0d addr=%0d data=%h required none", o_buf_sel, o_buf_addr, o_buf_wdata);
        end else begin
          exp_w = sb.pop_front();
          if ({o_buf_sel, o_buf_addr, o_buf_wdata} !== exp_w) begin
            n_bad++;
            $display("FAIL buf_write got sel=%0d addr=%0d data=%h required sel=%0d addr=%0d data=%h",
                     o_buf_sel, o_buf_addr, o_buf_wdata, exp_w.sel, exp_w.addr, exp_w.data);
          end
        end
      end
      if (o_req_done) begin
        ndone++;
        ndone_all++;
        if (exp_total != 0) begin
          n_total++;
          if (!(we_prev && sb.size() == 0)) begin
            n_bad++;
            $display("FAIL done_timing got prev_we=%0d pending=%0d required prev_we=1 pending=0", we_prev, sb.size());
          end
        end
      end
      if (o_req_err) nerr++;
      if (hold_pend) begin
        nhold++;
        n_total++;
        if (o_mem_rd_req !== 1'b1 || o_mem_rd_addr !== hold_addr) begin
          n_bad++;
          $display("FAIL addr_hold got req=%0d addr=%h required req=1 addr=%h", o_mem_rd_req, o_mem_rd_addr, hold_addr);
        end
      end
      we_prev = o_buf_we;
      i_mem_rd_valid = vld_p[1];
      i_mem_rd_data  = dat_p[1];
      if (vld_p[1]) nvld++;
      vld_p[1] = vld_p[0];
      dat_p[1] = dat_p[0];
      ack_ph = ~ack_ph;
      ack = (ack_mode == 0) ? 1'b1 : ack_ph;
      i_mem_rd_ack = ack;
      acc = o_mem_rd_req && ack && !rst;
      vld_p[0] = acc;
      dat_p[0] = o_mem_rd_addr ^ 32'hA5A5_0000;
      hold_pend = o_mem_rd_req && !ack && !rst;
      hold_addr = o_mem_rd_addr;
      if (acc) begin
        exp_a = exp_base + 32'(4 * nacc);
        n_total++;
        if (o_mem_rd_addr !== exp_a) begin
          n_bad++;
          $display("FAIL rd_addr got %h required %h", o_mem_rd_addr, exp_a);
        end
        if (nacc == 0) first_acc = o_mem_rd_addr;
        last_acc = o_mem_rd_addr;
        sb.push_back({2'(exp_sel), 12'(nacc), exp_a ^ 32'hA5A5_0000});
        nacc++;
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic set_shape(input int w, input int c, input logic [31:0] base);
    q_width = 8'(w);
    q_channel = 8'(c);
    q_base_addr = base;
    exp_total = w * c;
  endtask

  task automatic start_load(input int row);
    tick();
    nacc = 0; nwr = 0; ndone = 0;
    exp_sel = row % 4;
    exp_base = q_base_addr + 32'(4 * row * exp_total);
    i_req_row = 8'(row);
    i_req_load = 1'b1;
    tick();
    i_req_load = 1'b0;
  endtask

  task automatic wait_done(input int target);
    for (int i = 0; i < 300; i++) begin
      if (ndone >= target) break;
      tick();
    end
    n_total++;
    if (ndone < target) begin
      n_bad++;
      $display("FAIL done_timeout got %0d required %0d", ndone, target);
    end
  endtask

  task automatic wait_writes(input int target);
    for (int i = 0; i < 300; i++) begin
      if (nwr >= target) break;
      tick();
    end
    n_total++;
    if (nwr < target) begin
      n_bad++;
      $display("FAIL write_timeout got %0d required %0d", nwr, target);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    n_total++;
    if ({o_mem_rd_req, o_mem_rd_addr, o_buf_we, o_buf_sel, o_buf_addr, o_buf_wdata, o_req_done, o_req_err} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs got req=%0d addr=%h we=%0d sel=%0d baddr=%0d wdata=%h done=%0d err=%0d required all 0",
               o_mem_rd_req, o_mem_rd_addr, o_buf_we, o_buf_sel, o_buf_addr, o_buf_wdata, o_req_done, o_req_err);
    end
    n_total++;
    if (o_busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %0d required 0", o_busy); end
    rst = 1'b0;
    repeat (2) tick();
  endtask

  task automatic test_basic();
    ack_mode = 0;
    set_shape(4, 2, 32'h1000);
    start_load(3);
    n_total++;
    if (o_busy !== 1'b1) begin n_bad++; $display("FAIL basic_busy got %0d required 1", o_busy); end
    wait_done(1);
    repeat (5) tick();
    n_total++;
    if (nwr != 8 || nacc != 8) begin n_bad++; $display("FAIL basic_count got writes=%0d reads=%0d required 8 8", nwr, nacc); end
    n_total++;
    if (first_acc !== 32'h1060 || last_acc !== 32'h107C) begin
      n_bad++; $display("FAIL basic_range got %h..%h required 00001060..0000107c", first_acc, last_acc);
    end
    n_total++;
    if (last_sel !== 2'd3) begin n_bad++; $display("FAIL basic_sel got %0d required 3", last_sel); end
    n_total++;
    if (ndone != 1 || o_busy !== 1'b0) begin n_bad++; $display("FAIL basic_done got dones=%0d busy=%0d required 1 0", ndone, o_busy); end
  endtask

  task automatic test_backpressure();
    ack_mode = 1;
    nhold = 0;
    set_shape(4, 2, 32'h1000);
    start_load(2);
    wait_done(1);
    repeat (5) tick();
    n_total++;
    if (nwr != 8 || nacc != 8 || ndone != 1) begin
      n_bad++; $display("FAIL bp_count got writes=%0d reads=%0d dones=%0d required 8 8 1", nwr, nacc, ndone);
    end
    n_total++;
    if (nhold == 0) begin n_bad++; $display("FAIL bp_stall got %0d held cycles required >0", nhold); end
    ack_mode = 0;
  endtask

  task automatic test_wrap_zero();
    set_shape(4, 2, 32'h2000);
    start_load(5);
    wait_done(1);
    repeat (3) tick();
    n_total++;
    if (last_sel !== 2'd1 || nwr != 8) begin n_bad++; $display("FAIL wrap_sel got sel=%0d writes=%0d required 1 8", last_sel, nwr); end
    set_shape(0, 2, 32'h2000);
    tick();
    nacc = 0; ndone = 0;
    i_req_row = 8'd1;
    i_req_load = 1'b1;
    tick();
    i_req_load = 1'b0;
    n_total++;
    if (o_req_done !== 1'b0) begin n_bad++; $display("FAIL zero_early got done=%0d required 0", o_req_done); end
    tick();
    n_total++;
    if (o_req_done !== 1'b1) begin n_bad++; $display("FAIL zero_done got %0d required 1", o_req_done); end
    tick();
    n_total++;
    if (o_req_done !== 1'b0 || o_busy !== 1'b0 || nacc != 0) begin
      n_bad++; $display("FAIL zero_after got done=%0d busy=%0d reads=%0d required 0 0 0", o_req_done, o_busy, nacc);
    end
  endtask

  task automatic test_collision();
    set_shape(4, 2, 32'h1000);
    start_load(2);
    nerr = 0;
    wait_writes(3);
    i_req_row = 8'd7;
    i_req_load = 1'b1;
    tick();
    i_req_load = 1'b0;
    n_total++;
    if (o_req_err !== 1'b1) begin n_bad++; $display("FAIL coll_err got %0d required 1", o_req_err); end
    tick();
    n_total++;
    if (o_req_err !== 1'b0) begin n_bad++; $display("FAIL coll_err_pulse got %0d required 0", o_req_err); end
    for (int i = 0; i < 300; i++) begin
      if (o_req_done === 1'b1) break;
      tick();
    end
    i_req_row = 8'd6;
    i_req_load = 1'b1;
    tick();
    i_req_load = 1'b0;
    n_total++;
    if (o_req_err !== 1'b1 || o_busy !== 1'b0) begin
      n_bad++; $display("FAIL coll_done_err got err=%0d busy=%0d required 1 0", o_req_err, o_busy);
    end
    repeat (10) tick();
    n_total++;
    if (ndone != 1 || nwr != 8 || nerr != 2 || o_busy !== 1'b0) begin
      n_bad++; $display("FAIL coll_intact got dones=%0d writes=%0d errs=%0d busy=%0d required 1 8 2 0", ndone, nwr, nerr, o_busy);
    end
  endtask

  task automatic test_reset_mid();
    int nwr0, nvld0, ndone0;
    set_shape(4, 2, 32'h1000);
    start_load(1);
    wait_writes(3);
    rst = 1'b1;
    #1;
    n_total++;
    if ({o_mem_rd_req, o_mem_rd_addr, o_buf_we, o_buf_sel, o_buf_addr, o_buf_wdata, o_req_done, o_busy, o_req_err} !== '0) begin
      n_bad++; $display("FAIL midrst_outputs got req=%0d we=%0d busy=%0d addr=%h required all 0", o_mem_rd_req, o_buf_we, o_busy, o_mem_rd_addr);
    end
    sb.delete();
    nwr0 = nwr; nvld0 = nvld; ndone0 = ndone;
    tick();
    rst = 1'b0;
    repeat (6) tick();
    n_total++;
    if (nwr != nwr0 || ndone != ndone0 || nvld <= nvld0) begin
      n_bad++; $display("FAIL midrst_late got writes=%0d dones=%0d late_valids=%0d required %0d %0d >0", nwr, ndone, nvld - nvld0, nwr0, ndone0);
    end
    start_load(4);
    wait_done(1);
    repeat (3) tick();
    n_total++;
    if (nwr != 8 || last_sel !== 2'd0 || sb.size() != 0) begin
      n_bad++; $display("FAIL midrst_fresh got writes=%0d sel=%0d pending=%0d required 8 0 0", nwr, last_sel, sb.size());
    end
  endtask

  task automatic test_back_to_back();
    int sel_exp[6] = '{0, 1, 2, 3, 0, 1};
    int base_done, base_err;
    set_shape(4, 2, 32'h4000);
    base_done = ndone_all;
    base_err = nerr;
    for (int r = 0; r < 6; r++) begin
      start_load(r);
      wait_done(1);
      n_total++;
      if (last_sel !== 2'(sel_exp[r]) || nwr != 8) begin
        n_bad++; $display("FAIL b2b_row%0d got sel=%0d writes=%0d required %0d 8", r, last_sel, nwr, sel_exp[r]);
      end
    end
    repeat (5) tick();
    n_total++;
    if (ndone_all - base_done != 6 || nerr != base_err) begin
      n_bad++; $display("FAIL b2b_total got dones=%0d errs=%0d required 6 %0d", ndone_all - base_done, nerr, base_err);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_wrap_zero();
    test_collision();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
